sar_result_capture: RTL and testbench



---
 rtl/sar_result_capture.sv | 137 +++++++++++++
 tb/tb_sar_result_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_result_capture.sv
// sar_result_capture: synchronises SAR end-of-conversion, captures/averages results and buffers them in a FIFO
module sar_result_capture #(
    parameter int RESULT_W    = 11,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          conv_done,
    input  logic [RESULT_W-1:0]           result_in,
    output logic [RESULT_W-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    overflow_cnt,
    input  logic                          clear_ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ACC_W = RESULT_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 > 0 ? AVG_LOG2 : 1;

    logic [SYNC_STAGES-1:0] sync_q, fill_q;
    logic                   prev_q, armed_q, cap_q, capv_q;
    logic [RESULT_W-1:0]    sample_q;
    logic [ACC_W-1:0]       acc_q, acc_d, sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   push_q, push_d, last, take;
    logic [RESULT_W-1:0]    push_data_q, pdata_d;
    logic [RESULT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_q, rd_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   pop, full, wr_en, drop;
    logic                   ovf_q;
    logic [7:0]             ovf_cnt_q;

    // Synchroniser with edge detect; armed only after a genuine low has crossed, so a level held through reset never counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], conv_done};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
            cap_q   <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Register the SAR word on each enabled capture pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            capv_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            capv_q <= cap_q & enable;
            if (cap_q & enable) sample_q <= result_in;
        end
    end

    // Accumulate samples; the last one of a group emits the truncated mean
    always_comb begin
        sum_d   = acc_q + ACC_W'(sample_q);
        last    = cnt_q == CNT_W'((1 << AVG_LOG2) - 1);
        take    = capv_q & enable;
        acc_d   = !enable ? '0 : take ? (last ? '0 : sum_d) : acc_q;
        cnt_d   = !enable ? '0 : take ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        push_d  = take & last;
        pdata_d = RESULT_W'(sum_d >> AVG_LOG2);
    end

    // Accumulator state and the registered push toward the FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            push_q <= push_d;
            if (push_d) push_data_q <= pdata_d;
        end
    end

    // FIFO control: a simultaneous pop frees the slot for a push when full
    always_comb begin
        pop     = out_valid & out_ready;
        full    = level_q == LVL_W'(FIFO_DEPTH);
        wr_en   = push_q & (~full | pop);
        drop    = push_q & full & ~pop;
        level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    end

    // FIFO storage and pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) mem_q[wr_q] <= push_data_q;
            wr_q    <= wr_q + PTR_W'(wr_en);
            rd_q    <= rd_q + PTR_W'(pop);
            level_q <= level_d;
        end
    end

    // Sticky overflow flag and saturating drop counter; clear beats a coincident drop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (clear_ovf) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop) begin
            ovf_q     <= 1'b1;
            ovf_cnt_q <= ovf_cnt_q + 8'(ovf_cnt_q != 8'hFF);
        end
    end

    assign out_data     = mem_q[rd_q];
    assign out_valid    = level_q != '0;
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;
    assign overflow_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_sar_result_capture.sv
// tb_sar_result_capture: scoreboard bench for pass-through and 4-sample averaging instances
module tb_sar_result_capture;
    localparam int RW    = 11;
    localparam int SS    = 2;
    localparam int DEPTH = 4;

    logic          clock = 0, reset = 1, enable = 1, conv_done = 0, clear_ovf = 0;
    logic [RW-1:0] result_in = '0;
    logic          man_rdy = 1, rnd_rdy = 0, rand_rdy = 0, rdy0;
    logic [RW-1:0] data0, data2;
    logic          valid0, valid2, ovf0, ovf2;
    logic [2:0]    lvl0, lvl2;
    logic [7:0]    cnt0, cnt2;

    assign rdy0 = rand_rdy ? rnd_rdy : man_rdy;

    sar_result_capture #(.RESULT_W(RW), .SYNC_STAGES(SS), .AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .conv_done(conv_done), .result_in(result_in),
        .out_data(data0), .out_valid(valid0), .out_ready(rdy0), .fifo_level(lvl0),
        .overflow(ovf0), .overflow_cnt(cnt0), .clear_ovf(clear_ovf));

    sar_result_capture #(.RESULT_W(RW), .SYNC_STAGES(SS), .AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .conv_done(conv_done), .result_in(result_in),
        .out_data(data2), .out_valid(valid2), .out_ready(1'b1), .fifo_level(lvl2),
        .overflow(ovf2), .overflow_cnt(cnt2), .clear_ovf(clear_ovf));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int q0[$], q2[$];
    int pend_sum = 0, pend_n = 0, m_ovf_cnt = 0, e0, e2;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pass-through queue bounded by FIFO depth; group-of-four mean for the averaging instance
    task automatic model_push(int v);
        if (q0.size() >= DEPTH) m_ovf_cnt = m_ovf_cnt < 255 ? m_ovf_cnt + 1 : 255;
        else q0.push_back(v);
        pend_sum += v;
        pend_n++;
        if (pend_n == 4) begin
            q2.push_back(pend_sum / 4);
            pend_sum = 0;
            pend_n = 0;
        end
    endtask

    task automatic convert(int v, int hi);
        @(negedge clock);
        result_in = RW'(v);
        conv_done = 1;
        if (enable) model_push(v);
        repeat (hi) @(negedge clock);
        conv_done = 0;
        repeat (6) @(negedge clock);
    endtask

    task automatic enable_pulse();
        @(negedge clock);
        enable = 0;
        pend_sum = 0;
        pend_n = 0;
        @(negedge clock);
        enable = 1;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_in_time", int'(n < 200), 1);
    endtask

    always @(negedge clock) rnd_rdy = 1'($urandom_range(0, 1));

    // Monitor: pop and compare whenever a DUT hands over a word
    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (valid0 && rdy0) begin
                e0 = q0.size() != 0 ? q0.pop_front() : -1;
                chk("u0_word", int'(data0), e0);
            end
            if (valid2) begin
                e2 = q2.size() != 0 ? q2.pop_front() : -1;
                chk("u2_word", int'(data2), e2);
            end
        end
    end

    initial begin
        int v;
        repeat (3) @(negedge clock);
        chk("rst_valid0", int'(valid0), 0);
        chk("rst_data0", int'(data0), 0);
        chk("rst_level0", int'(lvl0), 0);
        chk("rst_ovf0", int'(ovf0), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_valid2", int'(valid2), 0);
        reset = 0;
        repeat (6) @(negedge clock);

        @(negedge clock);
        result_in = '0;
        conv_done = 1;
        model_push(0);
        repeat (SS + 3) @(posedge clock);
        @(negedge clock);
        #1 chk("latency_early", int'(valid0), 0);
        @(negedge clock);
        #1 chk("latency_on", int'(valid0), 1);
        @(negedge clock);
        conv_done = 0;
        repeat (6) @(negedge clock);
        convert(11'h7FF, 3);
        convert(11'h2A5, 1);
        wait_empty();
        chk("passthru_ovf", int'(ovf0), 0);

        enable_pulse();
        convert(11'h100, 2);
        convert(11'h101, 1);
        convert(11'h102, 4);
        chk("avg_partial_level", int'(lvl2), 0);
        chk("avg_partial_valid", int'(valid2), 0);
        convert(11'h104, 2);
        wait_empty();

        man_rdy = 0;
        for (int i = 0; i < 6; i++) convert(int'($urandom_range(0, 2047)), 2);
        chk("ovf_level", int'(lvl0), DEPTH);
        chk("ovf_flag", int'(ovf0), 1);
        chk("ovf_cnt", int'(cnt0), m_ovf_cnt);
        chk("ovf_cnt_two", int'(cnt0), 2);
        chk("hold_head", int'(data0), q0[0]);
        repeat (3) @(negedge clock);
        chk("hold_head_later", int'(data0), q0[0]);
        man_rdy = 1;
        wait_empty();
        @(negedge clock);
        clear_ovf = 1;
        @(negedge clock);
        clear_ovf = 0;
        m_ovf_cnt = 0;
        chk("clear_ovf_flag", int'(ovf0), 0);
        chk("clear_ovf_cnt", int'(cnt0), 0);

        man_rdy = 0;
        for (int i = 0; i < 4; i++) convert(int'($urandom_range(0, 2047)), 1);
        chk("full_level", int'(lvl0), DEPTH);
        v = int'($urandom_range(0, 2047));
        @(negedge clock);
        result_in = RW'(v);
        conv_done = 1;
        repeat (SS + 3) @(posedge clock);
        @(negedge clock);
        man_rdy = 1;
        #3 model_push(v);
        @(negedge clock);
        man_rdy = 0;
        #1 chk("pushpop_level", int'(lvl0), DEPTH);
        chk("pushpop_cnt", int'(cnt0), m_ovf_cnt);
        chk("pushpop_ovf", int'(ovf0), 0);
        conv_done = 0;
        repeat (6) @(negedge clock);
        man_rdy = 1;
        wait_empty();

        enable_pulse();
        convert(11'h155, 1);
        convert(11'h0AA, 2);
        enable_pulse();
        for (int i = 0; i < 4; i++) convert(11'h3FF, 1 + i);
        wait_empty();

        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            while (q0.size() >= DEPTH && n < 100) begin
                @(negedge clock);
                n++;
            end
            if ($urandom_range(0, 9) == 0) enable_pulse();
            convert(int'($urandom_range(0, 2047)), int'($urandom_range(1, 6)));
        end
        rand_rdy = 0;
        man_rdy = 1;
        wait_empty();
        chk("random_no_drop", int'(cnt0), 0);

        enable_pulse();
        convert(11'h222, 1);
        convert(11'h333, 2);
        wait_empty();
        @(negedge clock);
        result_in = RW'(11'h7AA);
        conv_done = 1;
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
        #1 chk("inrst_valid0", int'(valid0), 0);
        chk("inrst_data0", int'(data0), 0);
        chk("inrst_level0", int'(lvl0), 0);
        chk("inrst_ovf0", int'(ovf0), 0);
        chk("inrst_cnt0", int'(cnt0), 0);
        chk("inrst_valid2", int'(valid2), 0);
        chk("inrst_data2", int'(data2), 0);
        q0.delete();
        q2.delete();
        pend_sum = 0;
        pend_n = 0;
        m_ovf_cnt = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        repeat (12) @(negedge clock);
        chk("held_high_level0", int'(lvl0), 0);
        chk("held_high_level2", int'(lvl2), 0);
        @(negedge clock);
        conv_done = 0;
        repeat (6) @(negedge clock);
        convert(11'h010, 1);
        convert(11'h020, 1);
        convert(11'h030, 1);
        convert(11'h044, 1);
        wait_empty();
        chk("final_level0", int'(lvl0), 0);
        chk("final_level2", int'(lvl2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
